// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states,
// request bundle and the alignment/byte-lane helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int TIMEOUT_DEF = 255;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic bad_req(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SIZE_X)
         | ((size == SIZE_H) & off[0])
         | ((size == SIZE_W) & (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_en(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (size == SIZE_B): be = 4'b0001 << off;
      (size == SIZE_H): be = 4'b0011 << {off[1], 1'b0};
      (size == SIZE_W): be = 4'b1111;
      default:          be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory-port and response signals of the load/store unit.
// slave = the unit, master = pipeline plus data memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata, mem_ack, rsp_ready,
    output req_ready, mem_en, mem_we, mem_be,
    output mem_addr, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata, mem_ack, rsp_ready,
    input  req_ready, mem_en, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it to 32 bits.
import mem_access_unit_pkg::*;

module mem_access_unit_load_align (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    case (size)
      SIZE_B:  data = {{24{sgn & b[7]}}, b};
      SIZE_H:  data = {{16{sgn & h[15]}}, h};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Non-pipelined load/store unit: one request in flight, byte-enabled
// word port to data memory, extended load data back to the pipeline.
import mem_access_unit_pkg::*;

module mem_access_unit #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_unit_if.slave bus
);
  logic [1:0]       state;
  req_t             req;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      load;
  logic             acc;

  assign acc = (state == ST_ACCESS);

  mem_access_unit_load_align u_load_align (
    .word (bus.mem_rdata),
    .off  (req.addr[1:0]),
    .size (req.size),
    .sgn  (req.sgn),
    .data (load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req     <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req <= '{we:    bus.req_we,
                     size:  bus.req_size,
                     sgn:   bus.req_signed,
                     addr:  bus.req_addr,
                     wdata: bus.req_wdata};
            cnt     <= '0;
            rdata_q <= '0;
            if (bad_req(bus.req_size, bus.req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              err_q <= 1'b0;
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // ACK takes priority over a timeout landing in the same cycle
          if (bus.mem_ack) begin
            rdata_q <= req.we ? 32'd0 : load;
            state   <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_wdata = req.wdata;
    case (req.size)
      SIZE_B:  bus.mem_wdata = {4{req.wdata[7:0]}};
      SIZE_H:  bus.mem_wdata = {2{req.wdata[15:0]}};
      default: bus.mem_wdata = req.wdata;
    endcase
  end

  assign bus.mem_en    = acc;
  assign bus.mem_we    = acc & req.we;
  assign bus.mem_be    = acc ? lane_en(req.size, req.addr[1:0]) : 4'b0000;
  assign bus.mem_addr  = {req.addr[31:2], 2'b00};
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
